wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the ARM pipeline: the producer side of the register-file write port. It registers the MEM/WB payload, selects between the ALU result and load data, and drives `Dest_wb`/`Result_wb`/`writeBack_en` into the register file, which samples on the falling clock edge. It absorbs multi-cycle loads with a `mem_ready` handshake, stalls upstream while a load is outstanding, and aborts hung loads after a bounded wait.

## Interface
Parameters:
- `MAX_WAIT`, 15: maximum cycles spent in WAIT before a load is aborted (1..255).
- `CNT_W`, 16: width of the retired-write counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `freeze`  in  1  global hazard freeze; blocks capture in IDLE.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_wb_en`  in  1  instruction writes a register.
- `in_mem_r_en`  in  1  instruction is a load.
- `in_dest`  in  4  destination register index.
- `in_alu_res`  in  32  ALU result.
- `mem_rdata`  in  32  load data, valid when `mem_ready`=1.
- `mem_ready`  in  1  load data valid this cycle.
- `Dest_wb`  out  4  register-file write index.
- `Result_wb`  out  32  register-file write data.
- `writeBack_en`  out  1  register-file write strobe, one cycle per write.
- `stall`  out  1  upstream must hold its payload.
- `r15_err`  out  1  one-cycle pulse: write to r15 suppressed.
- `mem_timeout`  out  1  one-cycle pulse: load aborted.
- `retired`  out  `CNT_W`  count of committed writes, saturating.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, posedge with `in_valid`=1, `freeze`=0:
  - Non-load with `in_wb_en`=1: `Result_wb`<=`in_alu_res`, `Dest_wb`<=`in_dest`, `writeBack_en`<=1.
  - Load with `mem_ready`=1: `Result_wb`<=`mem_rdata`, same as above.
  - Load with `mem_ready`=0: latch `in_dest` and `in_wb_en`, go to WAIT, clear the wait counter, `writeBack_en`<=0.
  - `in_wb_en`=0: nothing written. A load still waits for `mem_ready` but does not write.
- WAIT, posedge:
  - `mem_ready`=1: write `mem_rdata` to the latched dest if the latched wb_en is set, then go to IDLE.
  - Otherwise increment the counter. When the counter reaches `MAX_WAIT`, pulse `mem_timeout`, make no write, and go to IDLE.
  - `in_valid` and `freeze` are ignored in WAIT.
- `stall` = (state==WAIT), decoded from registered state with no combinational path from inputs.
- Dest 15: the register file holds r0..r14 only. Any commit to `Dest_wb`=15 is suppressed (`writeBack_en`=0) and `r15_err` pulses in the same cycle the write would have occurred.
- `retired` increments on every cycle `writeBack_en`=1 and holds at all-ones once saturated.
- `writeBack_en` is 0 on every cycle without a fresh commit. A held payload is never re-written.

## Timing
- Reset values (immediate, asynchronous): state IDLE, all outputs 0, `retired`=0, wait counter 0.
- ALU write and ready load: one-cycle latency. The write is visible at the register file on the negedge after the capturing posedge.
- Outputs change only on posedge, so they are stable across the sampling negedge.
- Slow load: write occurs at the first posedge with `mem_ready`=1 after entry to WAIT. `stall` falls at that same edge.
- Timeout: exactly `MAX_WAIT` posedges in WAIT with `mem_ready`=0, then abort.
- `rst` asserted mid-WAIT: the pending load is dropped with no write and no `mem_timeout` pulse.
- `mem_ready`=1 on the same edge the counter reaches `MAX_WAIT`: the data wins and is written, with no timeout.

## Structure
- Shared package `arm_pkg` holds `REG_PC`=4'd15, the `wb_state_t` enum {IDLE, WAIT}, and `REG_W`=32.
- One sub-module, `wb_wait_ctrl`, holds the FSM, wait counter and `stall`/`mem_timeout` generation. The datapath mux, output registers and `retired` counter stay in `wb_stage`.

## Test plan
- ALU write: `in_alu_res`=0xDEADBEEF, `in_dest`=3, `in_wb_en`=1 -> next cycle `writeBack_en`=1, `Dest_wb`=3, `Result_wb`=0xDEADBEEF, `retired`=1. The register file holds r3=0xDEADBEEF after the negedge.
- Slow load: load to r7 with `mem_ready` low for 3 cycles, then `mem_rdata`=0x1234 -> `stall`=1 for 3 cycles, a single write r7=0x1234, then `stall`=0.
- Timeout (`MAX_WAIT`=4): `mem_ready` held low -> `mem_timeout` pulses after 4 cycles in WAIT, no write, returns to IDLE.
- r15 write: `in_dest`=15, `in_wb_en`=1 -> `writeBack_en`=0, `r15_err`=1 for one cycle, `retired` unchanged.
- Reset mid-WAIT: `rst` pulse during WAIT -> all outputs 0 immediately. The next load to r2 with `mem_ready`=1 writes normally.
- Freeze and saturation: with `freeze`=1 in IDLE -> no capture. Force `retired`=0xFFFE, then perform 3 writes -> `retired`=0xFFFF.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions used by the write-back stage and its bench.
package arm_pkg;

  localparam int        REG_W  = 32;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB payload, load-data handshake and register-file write port of the write-back stage.
interface wb_stage_if #(
  parameter int CNT_W = 16
);
  import arm_pkg::*;

  logic              freeze;
  logic              in_valid;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [3:0]        in_dest;
  logic [REG_W-1:0]  in_alu_res;
  logic [REG_W-1:0]  mem_rdata;
  logic              mem_ready;

  logic [3:0]        Dest_wb;
  logic [REG_W-1:0]  Result_wb;
  logic              writeBack_en;
  logic              stall;
  logic              r15_err;
  logic              mem_timeout;
  logic [CNT_W-1:0]  retired;

  modport master (
    output freeze, in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_res, mem_rdata, mem_ready,
    input  Dest_wb, Result_wb, writeBack_en, stall, r15_err, mem_timeout, retired
  );

  modport slave (
    input  freeze, in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_res, mem_rdata, mem_ready,
    output Dest_wb, Result_wb, writeBack_en, stall, r15_err, mem_timeout, retired
  );

endinterface

// File: rtl/wb_wait_ctrl.sv
// Load-wait FSM: decides when a write commits, holds slow loads and aborts them after MAX_WAIT edges.
// Commit decision is combinational for the next edge; stall and mem_timeout come straight from flops.
module wb_wait_ctrl import arm_pkg::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       freeze,
  input  logic       in_wb_en,
  input  logic       in_mem_r_en,
  input  logic [3:0] in_dest,
  input  logic       mem_ready,
  output logic       commit_vld,
  output logic       commit_mem,
  output logic [3:0] commit_dest,
  output logic       stall,
  output logic       mem_timeout
);

  localparam int CW = 8;

  wb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pend_dest_q, pend_dest_d;
  logic          pend_wb_q, pend_wb_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_dest_q <= '0;
      pend_wb_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_dest_q <= pend_dest_d;
      pend_wb_q   <= pend_wb_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_dest_d = pend_dest_q;
    pend_wb_d   = pend_wb_q;
    timeout_d   = 1'b0;
    commit_vld  = 1'b0;
    commit_mem  = 1'b0;
    commit_dest = in_dest;

    case (state_q)
      IDLE: begin
        if (in_valid && !freeze) begin
          if (in_mem_r_en && !mem_ready) begin
            state_d     = WAIT;
            cnt_d       = '0;
            pend_dest_d = in_dest;
            pend_wb_d   = in_wb_en;
          end else begin
            commit_vld = in_wb_en;
            commit_mem = in_mem_r_en;
          end
        end
      end
      WAIT: begin
        // Ready data takes priority over an expiring wait budget.
        if (mem_ready) begin
          commit_vld  = pend_wb_q;
          commit_mem  = 1'b1;
          commit_dest = pend_dest_q;
          state_d     = IDLE;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall       = (state_q == WAIT);
  assign mem_timeout = timeout_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU/load data and drives a registered register-file write port, one-cycle latency.
// Raises stall while a load is outstanding; writes to r15 are dropped with an r15_err pulse.
module wb_stage import arm_pkg::*; #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  logic             commit_vld;
  logic             commit_mem;
  logic [3:0]       commit_dest;

  logic [REG_W-1:0] result_q, result_d;
  logic [3:0]       dest_q, dest_d;
  logic             we_q, we_d;
  logic             r15_q, r15_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  wb_wait_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .freeze      (bus.freeze),
    .in_wb_en    (bus.in_wb_en),
    .in_mem_r_en (bus.in_mem_r_en),
    .in_dest     (bus.in_dest),
    .mem_ready   (bus.mem_ready),
    .commit_vld  (commit_vld),
    .commit_mem  (commit_mem),
    .commit_dest (commit_dest),
    .stall       (bus.stall),
    .mem_timeout (bus.mem_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      dest_q    <= '0;
      we_q      <= 1'b0;
      r15_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      result_q  <= result_d;
      dest_q    <= dest_d;
      we_q      <= we_d;
      r15_q     <= r15_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    result_d  = result_q;
    dest_d    = dest_q;
    we_d      = 1'b0;
    r15_d     = 1'b0;
    retired_d = retired_q;
    if (commit_vld) begin
      result_d = commit_mem ? bus.mem_rdata : bus.in_alu_res;
      dest_d   = commit_dest;
      // The register file only implements r0..r14.
      if (commit_dest == REG_PC) begin
        r15_d = 1'b1;
      end else begin
        we_d = 1'b1;
        if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.Result_wb    = result_q;
  assign bus.Dest_wb      = dest_q;
  assign bus.writeBack_en = we_q;
  assign bus.r15_err      = r15_q;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset/saturation sequences, then random traffic against a model.
module tb_wb_stage;
  import arm_pkg::*;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(16)) bus_a ();
  wb_stage_if #(.CNT_W(2))  bus_b ();

  wb_stage #(.MAX_WAIT(MAXW), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  wb_stage #(.MAX_WAIT(MAXW), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Narrow-counter instance sees identical traffic; it exists to exercise saturation.
  assign bus_b.freeze      = bus_a.freeze;
  assign bus_b.in_valid    = bus_a.in_valid;
  assign bus_b.in_wb_en    = bus_a.in_wb_en;
  assign bus_b.in_mem_r_en = bus_a.in_mem_r_en;
  assign bus_b.in_dest     = bus_a.in_dest;
  assign bus_b.in_alu_res  = bus_a.in_alu_res;
  assign bus_b.mem_rdata   = bus_a.mem_rdata;
  assign bus_b.mem_ready   = bus_a.mem_ready;

  // Register file sampling the write port on the falling edge.
  logic [31:0] rf [16];
  always @(negedge clk) if (bus_a.writeBack_en) rf[bus_a.Dest_wb] <= bus_a.Result_wb;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr, input logic fz,
                       input logic [3:0] d, input logic [31:0] alu, input logic [31:0] rd,
                       input logic rdy);
    bus_a.in_valid    = v;
    bus_a.in_wb_en    = wb;
    bus_a.in_mem_r_en = mr;
    bus_a.freeze      = fz;
    bus_a.in_dest     = d;
    bus_a.in_alu_res  = alu;
    bus_a.mem_rdata   = rd;
    bus_a.mem_ready   = rdy;
  endtask

  typedef struct {
    logic v, wb, mr, fz;
    logic [3:0]  d;
    logic [31:0] alu, rd;
    logic rdy;
    logic e_we;
    logic [3:0]  e_dest;
    logic [31:0] e_res;
    logic e_stall, e_r15, e_to;
    int   e_ret;
  } vec_t;

  function automatic vec_t mk(logic v, logic wb, logic mr, logic fz, logic [3:0] d,
                              logic [31:0] alu, logic [31:0] rd, logic rdy,
                              logic e_we, logic [3:0] e_dest, logic [31:0] e_res,
                              logic e_stall, logic e_r15, logic e_to, int e_ret);
    vec_t r;
    r.v = v; r.wb = wb; r.mr = mr; r.fz = fz; r.d = d; r.alu = alu; r.rd = rd; r.rdy = rdy;
    r.e_we = e_we; r.e_dest = e_dest; r.e_res = e_res;
    r.e_stall = e_stall; r.e_r15 = e_r15; r.e_to = e_to; r.e_ret = e_ret;
    return r;
  endfunction

  // Transaction-level reference: one optional pending load plus a wait budget.
  bit          m_pending;
  logic [3:0]  m_pdest;
  bit          m_pwb;
  int          m_waited;
  int          m_ret;
  logic [3:0]  m_dest;
  logic [31:0] m_res;
  bit          e_we, e_r15, e_to;

  task automatic model_reset();
    m_pending = 0; m_pwb = 0; m_waited = 0; m_ret = 0;
    m_dest = '0; m_res = '0; e_we = 0; e_r15 = 0; e_to = 0;
  endtask

  task automatic model_step();
    bit          commit;
    logic [3:0]  cd;
    logic [31:0] cv;
    commit = 0; cd = '0; cv = '0; e_to = 0;
    if (m_pending) begin
      if (bus_a.mem_ready) begin
        commit = m_pwb; cd = m_pdest; cv = bus_a.mem_rdata; m_pending = 0;
      end else begin
        m_waited++;
        if (m_waited >= MAXW) begin e_to = 1; m_pending = 0; end
      end
    end else if (bus_a.in_valid && !bus_a.freeze) begin
      if (bus_a.in_mem_r_en && !bus_a.mem_ready) begin
        m_pending = 1; m_pdest = bus_a.in_dest; m_pwb = bus_a.in_wb_en; m_waited = 0;
      end else if (bus_a.in_wb_en) begin
        commit = 1; cd = bus_a.in_dest;
        cv = bus_a.in_mem_r_en ? bus_a.mem_rdata : bus_a.in_alu_res;
      end
    end
    e_we  = commit && (cd != 4'd15);
    e_r15 = commit && (cd == 4'd15);
    if (e_we) begin
      m_dest = cd; m_res = cv;
      if (m_ret < 65535) m_ret++;
    end
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);

    // Asynchronous reset state
    #2;
    chk("rst_we",      {31'd0, bus_a.writeBack_en}, 32'd0);
    chk("rst_dest",    {28'd0, bus_a.Dest_wb},      32'd0);
    chk("rst_res",     bus_a.Result_wb,             32'd0);
    chk("rst_stall",   {31'd0, bus_a.stall},        32'd0);
    chk("rst_r15",     {31'd0, bus_a.r15_err},      32'd0);
    chk("rst_to",      {31'd0, bus_a.mem_timeout},  32'd0);
    chk("rst_retired", {16'd0, bus_a.retired},      32'd0);
    @(negedge clk); rst = 1'b0;

    //         v  wb mr fz dest   alu            rdata          rdy  we dest  res           st r15 to ret
    tbl.push_back(mk(1, 1, 0, 0, 4'd3,  32'hDEADBEEF, 32'h0,        0,   1, 4'd3,  32'hDEADBEEF, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd3,  32'hDEADBEEF, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'd15, 32'h11,       32'h0,        0,   0, 4'd0,  32'h0,        0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 4'd4,  32'h22,       32'h0,        0,   0, 4'd0,  32'h0,        0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 4'd6,  32'h33,       32'h0,        0,   0, 4'd0,  32'h0,        0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 4'd5,  32'h44,       32'hCAFE,     1,   1, 4'd5,  32'hCAFE,     0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 4'd8,  32'h0,        32'h66,       1,   0, 4'd0,  32'h0,        0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 1, 0, 4'd7,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 0, 0, 4'd1,  32'hBAD,      32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h1234,     1,   1, 4'd7,  32'h1234,     0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 0, 4'd9,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 0, 4'd10, 32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h55,       1,   1, 4'd10, 32'h55,       0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 1, 0, 4'd11, 32'h0,        32'h0,        0,   0, 4'd0,  32'h0,        1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0,  32'h0,        32'h77,       1,   0, 4'd0,  32'h0,        0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 1, 0, 4'd15, 32'h0,        32'h99,       1,   0, 4'd0,  32'h0,        0, 1, 0, 4));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].wb, tbl[i].mr, tbl[i].fz, tbl[i].d, tbl[i].alu, tbl[i].rd, tbl[i].rdy);
      tick();
      chk($sformatf("v%0d_we", i),    {31'd0, bus_a.writeBack_en}, {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_stall", i), {31'd0, bus_a.stall},        {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_r15", i),   {31'd0, bus_a.r15_err},      {31'd0, tbl[i].e_r15});
      chk($sformatf("v%0d_to", i),    {31'd0, bus_a.mem_timeout},  {31'd0, tbl[i].e_to});
      chk($sformatf("v%0d_ret", i),   {16'd0, bus_a.retired},      32'(tbl[i].e_ret));
      chk($sformatf("v%0d_ret_sat", i), {30'd0, bus_b.retired},
          32'((tbl[i].e_ret > 3) ? 3 : tbl[i].e_ret));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_dest", i), {28'd0, bus_a.Dest_wb}, {28'd0, tbl[i].e_dest});
        chk($sformatf("v%0d_res", i),  bus_a.Result_wb,        tbl[i].e_res);
      end
    end
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);
    @(negedge clk); #1;
    chk("rf_r3",  rf[3],  32'hDEADBEEF);
    chk("rf_r5",  rf[5],  32'hCAFE);
    chk("rf_r7",  rf[7],  32'h1234);
    chk("rf_r10", rf[10], 32'h55);
    chk("rf_r9",  rf[9],  32'h0);
    chk("rf_r11", rf[11], 32'h0);
    chk("rf_r6",  rf[6],  32'h0);
    chk("rf_r15", rf[15], 32'h0);

    // Reset in the middle of a wait drops the load silently
    drive(1, 1, 1, 0, 4'd6, 32'h0, 32'h0, 0);
    tick();
    chk("mw_stall", {31'd0, bus_a.stall}, 32'd1);
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mw_rst_stall",   {31'd0, bus_a.stall},        32'd0);
    chk("mw_rst_we",      {31'd0, bus_a.writeBack_en}, 32'd0);
    chk("mw_rst_res",     bus_a.Result_wb,             32'd0);
    chk("mw_rst_dest",    {28'd0, bus_a.Dest_wb},      32'd0);
    chk("mw_rst_retired", {16'd0, bus_a.retired},      32'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < MAXW + 2; k++) begin
      tick();
      chk($sformatf("mw_quiet%0d_to", k), {31'd0, bus_a.mem_timeout}, 32'd0);
      chk($sformatf("mw_quiet%0d_we", k), {31'd0, bus_a.writeBack_en}, 32'd0);
    end
    drive(1, 1, 1, 0, 4'd2, 32'h0, 32'hA5A5, 1);
    tick();
    chk("mw_r2_we",   {31'd0, bus_a.writeBack_en}, 32'd1);
    chk("mw_r2_dest", {28'd0, bus_a.Dest_wb},      32'd2);
    chk("mw_r2_res",  bus_a.Result_wb,             32'hA5A5);
    chk("mw_r2_ret",  {16'd0, bus_a.retired},      32'd1);

    // Saturation of the narrow counter across three more writes
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 4'd1, 32'(k), 32'h0, 0);
      tick();
      chk($sformatf("sat%0d_wide", k),   {16'd0, bus_a.retired}, 32'(k + 2));
      chk($sformatf("sat%0d_narrow", k), {30'd0, bus_b.retired}, 32'((k + 2 > 3) ? 3 : k + 2));
    end
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0);

    // Random traffic against the model
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 2) == 0);
      model_step();
      tick();
      chk("rnd_we",    {31'd0, bus_a.writeBack_en}, {31'd0, e_we});
      chk("rnd_r15",   {31'd0, bus_a.r15_err},      {31'd0, e_r15});
      chk("rnd_to",    {31'd0, bus_a.mem_timeout},  {31'd0, e_to});
      chk("rnd_stall", {31'd0, bus_a.stall},        {31'd0, m_pending});
      chk("rnd_ret",   {16'd0, bus_a.retired},      32'(m_ret));
      chk("rnd_ret_sat", {30'd0, bus_b.retired},    32'((m_ret > 3) ? 3 : m_ret));
      if (e_we) begin
        chk("rnd_dest", {28'd0, bus_a.Dest_wb}, {28'd0, m_dest});
        chk("rnd_res",  bus_a.Result_wb,        m_res);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
